// File: rtl/serial_adder_ctrl.sv
// Initiator-side controller for a bit-serial adder: takes parallel operands, streams them LSB-first
// with load framing, and reassembles the returned serial sum and final carry into a parallel result.
module serial_adder_ctrl #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         si_1,
    output logic         si_2,
    output logic         load,
    input  logic         sum_in,
    input  logic         cy_in,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [N-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    logic [CW-1:0]  r_bit_cnt;
    logic [CW-1:0]  r_cap_cnt;
    logic [LAT-1:0] r_cap_pipe;
    logic [N-1:0]   r_result;
    logic           r_carry;
    logic           r_cool;

    logic w_in_ready;
    logic w_accept;
    logic w_load;
    logic w_cap_en;
    logic w_last_bit;
    logic w_last_cap;
    logic w_release;

    // r_cool holds off in_ready for one cycle after a result is consumed.
    assign w_in_ready = (r_state == StIdle) && !r_cool;
    assign w_accept   = in_valid && w_in_ready;
    assign w_load     = (r_state == StShift);
    assign w_cap_en   = r_cap_pipe[LAT-1];
    assign w_last_bit = (r_bit_cnt == CW'(N - 1));
    assign w_last_cap = w_cap_en && (r_cap_cnt == CW'(N - 1));
    assign w_release  = (r_state == StDone) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (w_last_bit) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_last_cap) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_bit_cnt <= '0;
            r_cool    <= 1'b0;
        end else begin
            r_cool <= w_release;
            if (w_accept) begin
                r_op_a    <= a_in;
                r_op_b    <= b_in;
                r_bit_cnt <= '0;
            end else if (w_load) begin
                r_op_a    <= r_op_a >> 1;
                r_op_b    <= r_op_b >> 1;
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
        end
    end

    // Capture window trails load by the peer's latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_pipe <= '0;
        end else begin
            r_cap_pipe[0] <= w_load;
            for (int i = 1; i < LAT; i++) begin
                r_cap_pipe[i] <= r_cap_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_cap_cnt <= '0;
        end else if (w_accept) begin
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_cap_cnt <= '0;
        end else if (w_cap_en) begin
            r_result  <= {sum_in, r_result[N-1:1]};
            r_cap_cnt <= r_cap_cnt + CW'(1);
            if (w_last_cap) begin
                r_carry <= cy_in;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign load      = w_load;
    assign si_1      = w_load & r_op_a[0];
    assign si_2      = w_load & r_op_b[0];
    assign result    = r_result;
    assign carry     = r_carry;
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: two controllers (LAT=1 and LAT=3) each paired with a registered serial
// full-adder peer; stimulus and expected values are hand-computed.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // LAT=1 instance
    logic       u1_in_ready, u1_si1, u1_si2, u1_load, u1_sum, u1_cy, u1_carry, u1_ov, u1_busy;
    logic [3:0] u1_result;
    // LAT=3 instance
    logic       u3_in_ready, u3_si1, u3_si2, u3_load, u3_sum, u3_cy, u3_carry, u3_ov, u3_busy;
    logic [3:0] u3_result;

    serial_adder_ctrl #(.N(4), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid & ~sel), .in_ready(u1_in_ready),
        .si_1(u1_si1), .si_2(u1_si2), .load(u1_load),
        .sum_in(u1_sum), .cy_in(u1_cy),
        .result(u1_result), .carry(u1_carry), .out_valid(u1_ov),
        .out_ready(out_ready & ~sel), .busy(u1_busy)
    );

    serial_adder_ctrl #(.N(4), .LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid & sel), .in_ready(u3_in_ready),
        .si_1(u3_si1), .si_2(u3_si2), .load(u3_load),
        .sum_in(u3_sum), .cy_in(u3_cy),
        .result(u3_result), .carry(u3_carry), .out_valid(u3_ov),
        .out_ready(out_ready & sel), .busy(u3_busy)
    );

    // Peer for LAT=1: registered full adder, carry cleared on load rise.
    logic p1_ld, p1_s, p1_c, p1_cin;
    assign p1_cin = (u1_load & ~p1_ld) ? 1'b0 : p1_c;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_ld <= 1'b0;
            p1_s  <= 1'b0;
            p1_c  <= 1'b0;
        end else begin
            p1_ld <= u1_load;
            if (u1_load) begin
                p1_s <= u1_si1 ^ u1_si2 ^ p1_cin;
                p1_c <= (u1_si1 & u1_si2) | (p1_cin & (u1_si1 ^ u1_si2));
            end
        end
    end
    assign u1_sum = p1_s;
    assign u1_cy  = p1_c;

    // Peer for LAT=3: same adder plus two extra pipe stages.
    logic       p3_ld, p3_s, p3_c, p3_cin;
    logic [1:0] p3_d1, p3_d2;
    assign p3_cin = (u3_load & ~p3_ld) ? 1'b0 : p3_c;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p3_ld <= 1'b0;
            p3_s  <= 1'b0;
            p3_c  <= 1'b0;
            p3_d1 <= '0;
            p3_d2 <= '0;
        end else begin
            p3_ld <= u3_load;
            if (u3_load) begin
                p3_s <= u3_si1 ^ u3_si2 ^ p3_cin;
                p3_c <= (u3_si1 & u3_si2) | (p3_cin & (u3_si1 ^ u3_si2));
            end
            p3_d1 <= {p3_s, p3_c};
            p3_d2 <= p3_d1;
        end
    end
    assign u3_sum = p3_d2[1];
    assign u3_cy  = p3_d2[0];

    // Selected-instance view used by the transaction task.
    logic       m_in_ready, m_si1, m_si2, m_load, m_carry, m_ov, m_busy;
    logic [3:0] m_result;
    assign m_in_ready = sel ? u3_in_ready : u1_in_ready;
    assign m_si1      = sel ? u3_si1      : u1_si1;
    assign m_si2      = sel ? u3_si2      : u1_si2;
    assign m_load     = sel ? u3_load     : u1_load;
    assign m_carry    = sel ? u3_carry    : u1_carry;
    assign m_ov       = sel ? u3_ov       : u1_ov;
    assign m_busy     = sel ? u3_busy     : u1_busy;
    assign m_result   = sel ? u3_result   : u1_result;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] er,
                          input logic ec, input int lat_exp, input int hold);
        int cyc;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        check("idle_ready", m_in_ready, 1);
        adv();
        in_valid = 1'b0;
        cyc      = 1;
        check("busy", m_busy, 1);
        for (int k = 0; k < 4; k++) begin
            check("load", m_load, 1);
            check("si_1", m_si1, a[k]);
            check("si_2", m_si2, b[k]);
            check("shift_not_ready", m_in_ready, 0);
            adv();
            cyc++;
        end
        while (!m_ov && cyc < 30) begin
            check("si_quiet", {m_load, m_si1, m_si2}, 0);
            adv();
            cyc++;
        end
        check("latency", cyc, lat_exp);
        check("result", m_result, er);
        check("carry", m_carry, ec);
        for (int h = 0; h < hold; h++) begin
            adv();
            check("hold_valid", m_ov, 1);
            check("hold_ready", m_in_ready, 0);
            check("hold_result", m_result, er);
            check("hold_carry", m_carry, ec);
        end
        out_ready = 1'b1;
        adv();
        out_ready = 1'b0;
        check("ov_fall", m_ov, 0);
        check("ready_gap", m_in_ready, 0);
        adv();
        check("ready_back", m_in_ready, 1);
    endtask

    initial begin
        int acc0, acc1, nacc, nres;

        #3;
        check("rst_in_ready", u1_in_ready, 1);
        check("rst_load", u1_load, 0);
        check("rst_si", {u1_si1, u1_si2}, 0);
        check("rst_result", u1_result, 0);
        check("rst_carry", u1_carry, 0);
        check("rst_out_valid", u1_ov, 0);
        check("rst_busy", u1_busy, 0);
        #9;
        rst = 1'b0;
        adv();
        adv();

        sel = 1'b0;
        do_txn(4'b1011, 4'b0110, 4'b0001, 1'b1, 6, 0);
        do_txn(4'hF, 4'h1, 4'h0, 1'b1, 6, 0);
        do_txn(4'h0, 4'h0, 4'h0, 1'b0, 6, 5);
        do_txn(4'h5, 4'h3, 4'h8, 1'b0, 6, 2);

        // Back-to-back with in_valid held and out_ready high early.
        a_in      = 4'd3;
        b_in      = 4'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc0 = 0; acc1 = 0; nacc = 0; nres = 0;
        for (int j = 0; j < 40 && nres < 2; j++) begin
            if (u1_in_ready && in_valid) begin
                if (nacc == 0) acc0 = j;
                else acc1 = j;
                nacc++;
            end
            if (u1_ov) begin
                if (nres == 0) begin
                    check("b2b_res0", u1_result, 4'h8);
                    check("b2b_cy0", u1_carry, 0);
                end else begin
                    check("b2b_res1", u1_result, 4'h2);
                    check("b2b_cy1", u1_carry, 1);
                end
                nres++;
            end
            adv();
            if (nacc == 1) begin
                a_in = 4'd9;
                b_in = 4'd9;
            end
            if (nacc >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("b2b_nres", nres, 2);
        check("b2b_nacc", nacc, 2);
        check("b2b_spacing", acc1 - acc0, 8);
        adv();
        check("b2b_idle", u1_in_ready, 1);

        // Reset in the second SHIFT cycle.
        a_in     = 4'h5;
        b_in     = 4'h6;
        in_valid = 1'b1;
        adv();
        in_valid = 1'b0;
        adv();
        check("mid_load", u1_load, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_load", u1_load, 0);
        check("mid_rst_busy", u1_busy, 0);
        check("mid_rst_ov", u1_ov, 0);
        check("mid_rst_result", u1_result, 0);
        check("mid_rst_ready", u1_in_ready, 1);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            adv();
            check("post_rst_quiet", {u1_ov, u1_load, u1_busy}, 0);
        end
        do_txn(4'h7, 4'h7, 4'hE, 1'b0, 6, 0);

        // LAT=3 instance.
        sel = 1'b1;
        do_txn(4'd12, 4'd10, 4'h6, 1'b1, 8, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
